axi_sram: RTL and testbench

AXI-lite slave memory that sits directly downstream of the IFU/EXU arbiter and answers the single shared AR/R/AW/W/B channel set the arbiter forwards. It holds a word-addressed internal array mapped at a fixed base address. Each accepted read or write is answered after a programmable latency, so arbiter and core stall paths are exercised. Read and write paths are independent FSMs, each with one transaction outstanding.

---
 rtl/axi_sram_if.sv | 30 +++
 rtl/axi_sram.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_sram.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_if.sv
// AXI-lite channel bundle (AR/R/AW/W/B) between the arbiter and the SRAM slave.
interface axi_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [31:0] rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [31:0] bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_sram.sv
// Word-addressed AXI-lite SRAM slave with independent read/write FSMs and
// programmable response latency; one transaction outstanding per direction.
module axi_sram #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          DEPTH_LOG2    = 12,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst,
    axi_sram_if.slave bus
);
    localparam int         WORDS  = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;

    function automatic logic addr_hit(input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (off >> (DEPTH_LOG2 + 2)) == 33'd0;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [31:0] addr);
        return DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem_q [WORDS];

    r_state_e    r_state_q;
    logic [3:0]  r_cnt_q;
    logic [31:0] r_addr_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    w_state_e    w_state_q;
    logic [3:0]  w_cnt_q;
    logic        aw_have_q;
    logic        w_have_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic [31:0]           r_cap_addr_s;
    logic                  r_cap_hit_s;
    logic [DEPTH_LOG2-1:0] r_cap_idx_s;
    logic                  aw_now_s;
    logic                  w_now_s;
    logic                  w_commit_s;
    logic [31:0]           cmt_addr_s;
    logic [31:0]           cmt_data_s;
    logic [3:0]            cmt_strb_s;
    logic                  cmt_hit_s;
    logic [DEPTH_LOG2-1:0] cmt_idx_s;
    logic                  unused_s;

    assign unused_s = ^bus.wstrb[7:4];

    // Read-capture address: the live AR when latency is zero, otherwise the held one
    always_comb begin
        if (r_state_q == R_IDLE) begin
            r_cap_addr_s = bus.araddr;
        end else begin
            r_cap_addr_s = r_addr_q;
        end
        r_cap_hit_s = addr_hit(r_cap_addr_s);
        r_cap_idx_s = addr_idx(r_cap_addr_s);
    end

    // Read FSM: accept AR, count down the latency, present data until rready
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= 4'd0;
            r_addr_q  <= 32'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'd0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        arready_q <= 1'b0;
                        r_addr_q  <= bus.araddr;
                        if (RD_LAT == 4'd0) begin
                            r_state_q <= R_RESP;
                            rvalid_q  <= 1'b1;
                            rdata_q   <= r_cap_hit_s ? mem_q[r_cap_idx_s] : 32'd0;
                            rresp_q   <= r_cap_hit_s ? 2'd0 : 2'd2;
                        end else begin
                            r_cnt_q   <= RD_LAT;
                            r_state_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == 4'd1) begin
                        r_cnt_q   <= 4'd0;
                        r_state_q <= R_RESP;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= r_cap_hit_s ? mem_q[r_cap_idx_s] : 32'd0;
                        rresp_q   <= r_cap_hit_s ? 2'd0 : 2'd2;
                    end else begin
                        r_cnt_q <= r_cnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Commit source: in W_IDLE either half may still be arriving on the bus this cycle
    always_comb begin
        aw_now_s   = aw_have_q | (bus.awvalid & awready_q);
        w_now_s    = w_have_q | (bus.wvalid & wready_q);
        cmt_addr_s = awaddr_q;
        cmt_data_s = wdata_q;
        cmt_strb_s = wstrb_q;
        if (w_state_q == W_IDLE) begin
            cmt_addr_s = aw_have_q ? awaddr_q : bus.awaddr;
            cmt_data_s = w_have_q ? wdata_q : bus.wdata;
            cmt_strb_s = w_have_q ? wstrb_q : bus.wstrb[3:0];
            w_commit_s = rst & (WR_LAT == 4'd0) & aw_now_s & w_now_s;
        end else if (w_state_q == W_WAIT) begin
            w_commit_s = rst & (w_cnt_q == 4'd1);
        end else begin
            w_commit_s = 1'b0;
        end
        cmt_hit_s = addr_hit(cmt_addr_s);
        cmt_idx_s = addr_idx(cmt_addr_s);
    end

    // Byte-enabled array write; the array has no reset so contents survive rst
    always_ff @(posedge clk) begin
        if (w_commit_s && cmt_hit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt_strb_s[i]) begin
                    mem_q[cmt_idx_s][8*i +: 8] <= cmt_data_s[8*i +: 8];
                end
            end
        end
    end

    // Write FSM: collect AW and W in any order, count down, respond until bready
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= 4'd0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (bus.awvalid && awready_q) begin
                        awaddr_q <= bus.awaddr;
                    end
                    if (bus.wvalid && wready_q) begin
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb[3:0];
                    end
                    if (aw_now_s && w_now_s) begin
                        aw_have_q <= 1'b0;
                        w_have_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (WR_LAT == 4'd0) begin
                            w_state_q <= W_RESP;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= cmt_hit_s ? 2'd0 : 2'd2;
                        end else begin
                            w_cnt_q   <= WR_LAT;
                            w_state_q <= W_WAIT;
                        end
                    end else begin
                        aw_have_q <= aw_now_s;
                        w_have_q  <= w_now_s;
                        awready_q <= ~aw_now_s;
                        wready_q  <= ~w_now_s;
                    end
                end
                W_WAIT: begin
                    if (w_cnt_q == 4'd1) begin
                        w_cnt_q   <= 4'd0;
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= cmt_hit_s ? 2'd0 : 2'd2;
                    end else begin
                        w_cnt_q <= w_cnt_q - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready flags are forced low combinationally while reset is held
    assign bus.arready = rst & arready_q;
    assign bus.awready = rst & awready_q;
    assign bus.wready  = rst & wready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = {30'd0, rresp_q};
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = {30'd0, bresp_q};
endmodule

// File: tb/tb_axi_sram.sv
// Scoreboard bench for axi_sram: expected R/B responses are queued at issue
// and compared by a monitor when the DUT completes the handshake.
module tb_axi_sram;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [33:0] r_exp_q [$];
    logic [1:0]  b_exp_q [$];
    logic [33:0] r_e;
    logic [1:0]  b_e;

    axi_sram_if bus ();

    axi_sram #(
        .BASE_ADDR    (32'h8000_0000),
        .DEPTH_LOG2   (12),
        .READ_LATENCY (2),
        .WRITE_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_d;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_d[8*i +: 8];
        return r;
    endfunction

    // Scoreboard monitor: compare at the negedge before each accepting posedge
    always @(negedge clk) begin
        if (rst && bus.rvalid && bus.rready) begin
            if (r_exp_q.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
            else begin
                r_e = r_exp_q.pop_front();
                chk("rdata", bus.rdata, r_e[31:0]);
                chk("rresp", bus.rresp, {30'd0, r_e[33:32]});
            end
        end
        if (rst && bus.bvalid && bus.bready) begin
            if (b_exp_q.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else begin
                b_e = b_exp_q.pop_front();
                chk("bresp", bus.bresp, {30'd0, b_e});
            end
        end
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                      input int hold, output int lat);
        bit seen;
        bit early;
        lat = 0;
        seen = 1'b0;
        early = 1'b0;
        r_exp_q.push_back({exp_r, exp_d});
        bus.araddr = a;
        bus.arvalid = 1'b1;
        bus.rready = (hold == 0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.arready;
        end
        chk("ar_handshake", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.arready) early = 1'b1;
            if (bus.rvalid) lat = i;
        end
        if (lat == 0) begin
            chk("r_timeout", 32'd0, 32'd1);
            bus.rready = 1'b1;
            return;
        end
        chk("ar_busy", {31'd0, early}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk("r_hold_valid", {31'd0, bus.rvalid}, 32'd1);
            chk("r_hold_data", bus.rdata, exp_d);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.rready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("r_drop", {31'd0, bus.rvalid}, 32'd0);
        chk("ar_ready_again", {31'd0, bus.arready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_b, input int aw_lead, input int hold, output int lat);
        bit aw_done;
        bit w_done;
        bit aw_stall;
        bit early;
        aw_done = 1'b0;
        w_done = 1'b0;
        aw_stall = 1'b0;
        early = 1'b0;
        lat = 0;
        b_exp_q.push_back(exp_b);
        bus.awaddr = a;
        bus.awvalid = 1'b1;
        bus.wdata = d;
        bus.wstrb = {4'hF, s};
        bus.bready = (hold == 0);
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            if (c == aw_lead) bus.wvalid = 1'b1;
            @(negedge clk);
            if (aw_done && !w_done && bus.awready) aw_stall = 1'b1;
            if (bus.awvalid && bus.awready) aw_done = 1'b1;
            if (bus.wvalid && bus.wready) w_done = 1'b1;
            @(posedge clk); #1;
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
        end
        chk("w_handshake", {31'd0, aw_done && w_done}, 32'd1);
        chk("aw_stall", {31'd0, aw_stall}, 32'd0);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.awready || bus.wready) early = 1'b1;
            if (bus.bvalid) lat = i;
        end
        if (lat == 0) begin
            chk("b_timeout", 32'd0, 32'd1);
            bus.bready = 1'b1;
            return;
        end
        chk("aw_busy", {31'd0, early}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk("b_hold_valid", {31'd0, bus.bvalid}, 32'd1);
            chk("b_hold_resp", bus.bresp, {30'd0, exp_b});
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.bready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_drop", {31'd0, bus.bvalid}, 32'd0);
        chk("aw_ready_again", {31'd0, bus.awready & bus.wready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lw;
        int lr;
        bit seen;
        logic [31:0] a;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  s;
        bus.araddr = 32'd0;  bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awaddr = 32'd0;  bus.awvalid = 1'b0; bus.wdata = 32'd0;
        bus.wstrb = 8'd0;    bus.wvalid = 1'b0;  bus.bready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
        chk("rst_arready", {31'd0, bus.arready}, 32'd0);
        chk("rst_awready", {31'd0, bus.awready}, 32'd0);
        chk("rst_wready", {31'd0, bus.wready}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp", bus.rresp, 32'd0);
        chk("rst_bresp", bus.bresp, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd7);
        @(posedge clk); #1;

        // Basic write/read and latency
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0, 0, 0, lw);
        chk("b_latency", lw, 32'd3);
        rd(32'h8000_0010, 32'hDEAD_BEEF, 2'd0, 0, lr);
        chk("r_latency", lr, 32'd3);

        // Byte strobes
        wr(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 2'd0, 0, 0, lw);
        wr(32'h8000_0020, 32'h1122_3344, 4'hF, 2'd0, 0, 0, lw);
        wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'd0, 0, 0, lw);
        rd(32'h8000_0020, 32'h11BB_33DD, 2'd0, 0, lr);

        // Range boundaries
        rd(32'h7FFF_FFFC, 32'd0, 2'd2, 0, lr);
        wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'd2, 0, 0, lw);
        rd(32'h8000_0000, 32'h0BAD_F00D, 2'd0, 0, lr);
        wr(32'h8000_3FFF, 32'h7777_0001, 4'hF, 2'd0, 0, 0, lw);
        rd(32'h8000_3FFC, 32'h7777_0001, 2'd0, 0, lr);

        // AW ahead of W, with both responses back-pressured
        fork
            wr(32'h8000_0050, 32'hCAFE_F00D, 4'hF, 2'd0, 3, 4, lw);
            rd(32'h8000_0010, 32'hDEAD_BEEF, 2'd0, 4, lr);
        join
        rd(32'h8000_0050, 32'hCAFE_F00D, 2'd0, 0, lr);

        // Read capture and write commit on the same word in the same cycle
        wr(32'h8000_0030, 32'h0000_0001, 4'hF, 2'd0, 0, 0, lw);
        fork
            rd(32'h8000_0030, 32'h0000_0001, 2'd0, 0, lr);
            wr(32'h8000_0030, 32'h0000_0002, 4'hF, 2'd0, 0, 0, lw);
        join
        rd(32'h8000_0030, 32'h0000_0002, 2'd0, 0, lr);

        // Reset during R_WAIT / W_WAIT
        wr(32'h8000_0040, 32'h5555_AAAA, 4'hF, 2'd0, 0, 0, lw);
        bus.araddr = 32'h8000_0040; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0040; bus.awvalid = 1'b1;
        bus.wdata = 32'h1234_5678;  bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rel_ready", {29'd0, bus.arready, bus.awready, bus.wready}, 32'd7);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rvalid || bus.bvalid) seen = 1'b1;
        end
        chk("abort_no_resp", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        rd(32'h8000_0040, 32'h5555_AAAA, 2'd0, 0, lr);

        // Random partial writes over full ones
        for (int i = 0; i < 4; i++) begin
            a  = 32'h8000_0100 + 32'(i * 8);
            d0 = $urandom;
            d1 = $urandom;
            s  = 4'($urandom_range(0, 15));
            wr(a, d0, 4'hF, 2'd0, i % 2, 0, lw);
            wr(a, d1, s, 2'd0, 0, 0, lw);
            rd(a, merge(d0, d1, s), 2'd0, 0, lr);
        end

        chk("r_sb_empty", r_exp_q.size(), 32'd0);
        chk("b_sb_empty", b_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
